// File: rtl/warn_pkg.sv
// Shared types and default timing constants for the seat-belt / door warning chime.
package warn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRACE = 2'd1,
        ST_CHIME = 2'd2,
        ST_LAMP  = 2'd3
    } warn_state_e;

    localparam int DEF_DEB_TICKS   = 4;
    localparam int DEF_GRACE_TICKS = 8;
    localparam int DEF_BEEP_TICKS  = 2;
    localparam int DEF_CHIME_TICKS = 32;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/warning_chime_ctrl_if.sv
// Signal bundle between the vehicle-side inputs and the chime controller.
// Optional Snooze line exists only when WARN_SNOOZE_EN is defined.
interface warning_chime_ctrl_if;

    // No valid/ready handshake: all inputs are levels, and Tick is a one-clk
    // enable that qualifies every sample and timer step inside the block.
    logic       Tick;
    logic       DoorClose;
    logic       Ignition;
    logic       SeatBelt;
`ifdef WARN_SNOOZE_EN
    logic       Snooze;
`endif
    logic       Warning;
    logic       Chime;
    logic [1:0] State;

`ifdef WARN_SNOOZE_EN
    modport master (output Tick, DoorClose, Ignition, SeatBelt, Snooze,
                    input  Warning, Chime, State);
    modport slave  (input  Tick, DoorClose, Ignition, SeatBelt, Snooze,
                    output Warning, Chime, State);
`else
    modport master (output Tick, DoorClose, Ignition, SeatBelt,
                    input  Warning, Chime, State);
    modport slave  (input  Tick, DoorClose, Ignition, SeatBelt,
                    output Warning, Chime, State);
`endif

endinterface

// File: rtl/warn_debounce.sv
// Tick-sampled debouncer: output follows raw only after DEB_TICKS consecutive
// disagreeing samples; any agreeing sample restarts the count.
module warn_debounce #(
    parameter int   DEB_TICKS = 4,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [CW-1:0] cnt;

    // cnt never passes DEB_TICKS-1, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= RST_VAL;
        end else if (tick) begin
            if (raw == deb) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEB_TICKS - 1)) begin
                deb <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/warning_chime_ctrl.sv
// Seat-belt / door warning controller: debounced hazard -> grace -> chime -> lamp.
// Build option: WARN_SNOOZE_EN adds a Snooze input that cuts the chime short.
module warning_chime_ctrl
    import warn_pkg::*;
#(
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int GRACE_TICKS = DEF_GRACE_TICKS,
    parameter int BEEP_TICKS  = DEF_BEEP_TICKS,
    parameter int CHIME_TICKS = DEF_CHIME_TICKS
) (
    input logic                 clk,
    input logic                 rst_n,
    warning_chime_ctrl_if.slave bus
);

    localparam int TW = $clog2(max3(GRACE_TICKS, BEEP_TICKS, CHIME_TICKS) + 1);

    logic          door_d, ign_d, belt_d;
    logic          cond;
    warn_state_e   state;
    logic [TW-1:0] timer;
    logic [TW-1:0] beep_cnt;
    logic          warning_q;
    logic          chime_q;

    warn_debounce #(.DEB_TICKS(DEB_TICKS), .RST_VAL(1'b1)) u_deb_door (
        .clk(clk), .rst_n(rst_n), .tick(bus.Tick), .raw(bus.DoorClose), .deb(door_d));
    warn_debounce #(.DEB_TICKS(DEB_TICKS), .RST_VAL(1'b0)) u_deb_ign (
        .clk(clk), .rst_n(rst_n), .tick(bus.Tick), .raw(bus.Ignition), .deb(ign_d));
    warn_debounce #(.DEB_TICKS(DEB_TICKS), .RST_VAL(1'b1)) u_deb_belt (
        .clk(clk), .rst_n(rst_n), .tick(bus.Tick), .raw(bus.SeatBelt), .deb(belt_d));

    assign cond = ign_d & (~door_d | ~belt_d);

    // Hazard clearing wins over every other event, including timer expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            beep_cnt  <= '0;
            warning_q <= 1'b0;
            chime_q   <= 1'b0;
        end else if (state != ST_IDLE && !cond) begin
            state     <= ST_IDLE;
            timer     <= '0;
            beep_cnt  <= '0;
            warning_q <= 1'b0;
            chime_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cond) begin
                        state <= ST_GRACE;
                        timer <= '0;
                    end
                end
                ST_GRACE: begin
                    if (bus.Tick) begin
                        if (timer >= TW'(GRACE_TICKS - 1)) begin
                            state     <= ST_CHIME;
                            timer     <= '0;
                            beep_cnt  <= '0;
                            warning_q <= 1'b1;
                            chime_q   <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_CHIME: begin
`ifdef WARN_SNOOZE_EN
                    if (bus.Snooze) begin
                        state   <= ST_LAMP;
                        chime_q <= 1'b0;
                    end else
`endif
                    if (bus.Tick) begin
                        if (timer >= TW'(CHIME_TICKS - 1)) begin
                            state   <= ST_LAMP;
                            chime_q <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                            // Buzzer toggles every BEEP_TICKS ticks, starting on.
                            if (beep_cnt >= TW'(BEEP_TICKS - 1)) begin
                                beep_cnt <= '0;
                                chime_q  <= ~chime_q;
                            end else begin
                                beep_cnt <= beep_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_LAMP: begin
                    state <= ST_LAMP;
                end
            endcase
        end
    end

    assign bus.State   = state;
    assign bus.Warning = warning_q;
    assign bus.Chime   = chime_q;

endmodule

// File: tb/tb_warning_chime_ctrl.sv
// Directed scenarios plus random traffic, each clk compared against a
// tick-counting reference model of the warning behaviour.
module tb_warning_chime_ctrl;

    localparam int DEB   = 4;
    localparam int GRACE = 8;
    localparam int BEEP  = 2;
    localparam int CHIME = 32;

    logic clk;
    logic rst_n;

    warning_chime_ctrl_if bus_if ();

    warning_chime_ctrl #(
        .DEB_TICKS(DEB), .GRACE_TICKS(GRACE), .BEEP_TICKS(BEEP), .CHIME_TICKS(CHIME)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ph    = 0;

    bit ign, door, belt, snz;

    // Reference model: state number, ticks spent in current state, debounced
    // values and count of consecutive disagreeing samples per input.
    int m_st, m_n;
    bit m_ign, m_door, m_belt;
    int q_ign, q_door, q_belt;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_n = 0;
        m_ign = 1'b0; m_door = 1'b1; m_belt = 1'b1;
        q_ign = 0; q_door = 0; q_belt = 0;
    endtask

    task automatic deb_sample(inout bit d, inout int q, input bit s);
        if (s == d) q = 0;
        else begin
            q++;
            if (q == DEB) begin
                d = s;
                q = 0;
            end
        end
    endtask

    task automatic model_clock(input bit t, input bit s);
        bit c;
        c = m_ign && (!m_door || !m_belt);
        if (m_st != 0 && !c) begin
            m_st = 0; m_n = 0;
        end else begin
            case (m_st)
                0: if (c) begin m_st = 1; m_n = 0; end
                1: if (t) begin
                       m_n++;
                       if (m_n == GRACE) begin m_st = 2; m_n = 0; end
                   end
                2: if (s) m_st = 3;
                   else if (t) begin
                       m_n++;
                       if (m_n == CHIME) m_st = 3;
                   end
                default: ;
            endcase
        end
        if (t) begin
            deb_sample(m_ign,  q_ign,  ign);
            deb_sample(m_door, q_door, door);
            deb_sample(m_belt, q_belt, belt);
        end
    endtask

    task automatic check_model();
        bit exp_chime;
        exp_chime = (m_st == 2) && (((m_n / BEEP) % 2) == 0);
        check("state",   bus_if.State,         2'(m_st));
        check("warning", {1'b0, bus_if.Warning}, {1'b0, (m_st >= 2)});
        check("chime",   {1'b0, bus_if.Chime},   {1'b0, exp_chime});
    endtask

    task automatic step(input bit t);
        bus_if.Tick      = t;
        bus_if.Ignition  = ign;
        bus_if.DoorClose = door;
        bus_if.SeatBelt  = belt;
`ifdef WARN_SNOOZE_EN
        bus_if.Snooze    = snz;
`endif
        @(posedge clk);
        #1;
`ifdef WARN_SNOOZE_EN
        model_clock(t, snz);
`else
        model_clock(t, 1'b0);
`endif
        check_model();
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            step((ph % per) == (per - 1));
            ph++;
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_state",   bus_if.State,           2'd0);
        check("rst_warning", {1'b0, bus_if.Warning}, 2'd0);
        check("rst_chime",   {1'b0, bus_if.Chime},   2'd0);
        model_reset();
        bus_if.Tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        ign = 1'b0; door = 1'b1; belt = 1'b1; snz = 1'b0;
        bus_if.Tick = 1'b0;
        bus_if.Ignition = 1'b0; bus_if.DoorClose = 1'b1; bus_if.SeatBelt = 1'b1;
`ifdef WARN_SNOOZE_EN
        bus_if.Snooze = 1'b0;
`endif
        @(posedge clk);
        do_reset();
        run(8, 4);

        // Belt unfastened with ignition on, Tick every 4 clk.
        ign = 1'b1; belt = 1'b0; ph = 0;
        run(17, 4);
        check("s1_grace", bus_if.State, 2'd1);
        run(31, 4);
        check("s1_chime", bus_if.State, 2'd2);
        check("s1_beep_on", {1'b0, bus_if.Chime}, 2'd1);
        run(128, 4);
        check("s1_lamp", bus_if.State, 2'd3);
        check("s1_lamp_warn", {1'b0, bus_if.Warning}, 2'd1);
        check("s1_lamp_chime", {1'b0, bus_if.Chime}, 2'd0);
        run(20, 4);

        // Short belt glitch must be filtered.
        do_reset();
        ign = 1'b1; belt = 1'b1;
        run(20, 4);
        belt = 1'b0; ph = 0;
        run(12, 4);
        belt = 1'b1;
        run(20, 4);
        check("s2_idle", bus_if.State, 2'd0);
        check("s2_nowarn", {1'b0, bus_if.Warning}, 2'd0);

        // Belt fastened during CHIME.
        do_reset();
        ign = 1'b1; belt = 1'b0;
        run(60, 4);
        check("s3_in_chime", bus_if.State, 2'd2);
        belt = 1'b1; ph = 0;
        run(16, 4);
        check("s3_still_chime", bus_if.State, 2'd2);
        run(1, 4);
        check("s3_idle", bus_if.State, 2'd0);
        check("s3_warn_off", {1'b0, bus_if.Warning}, 2'd0);
        check("s3_chime_off", {1'b0, bus_if.Chime}, 2'd0);

        // Hazard clears on the same clk as the grace expiry tick.
        do_reset();
        ign = 1'b1; belt = 1'b0;
        run(8, 1);
        check("s4_grace", bus_if.State, 2'd1);
        belt = 1'b1;
        run(4, 1);
        check("s4_grace_last", bus_if.State, 2'd1);
        run(1, 1);
        check("s4_idle", bus_if.State, 2'd0);
        run(5, 1);
        check("s4_never_chime", bus_if.State, 2'd0);

`ifdef WARN_SNOOZE_EN
        // Snooze ignored in GRACE, honoured in CHIME.
        do_reset();
        ign = 1'b1; belt = 1'b0;
        run(8, 1);
        snz = 1'b1;
        run(1, 1);
        snz = 1'b0;
        check("s5_snooze_grace", bus_if.State, 2'd1);
        run(4, 1);
        check("s5_chime", bus_if.State, 2'd2);
        run(4, 1);
        snz = 1'b1;
        run(1, 1);
        snz = 1'b0;
        check("s5_lamp", bus_if.State, 2'd3);
        check("s5_chime_off", {1'b0, bus_if.Chime}, 2'd0);
        check("s5_warn_on", {1'b0, bus_if.Warning}, 2'd1);
`endif

        // Reset pulsed mid-CHIME, then re-debounce before GRACE.
        do_reset();
        ign = 1'b1; belt = 1'b0;
        run(60, 4);
        check("s6_chime", bus_if.State, 2'd2);
        do_reset();
        run(12, 4);
        check("s6_redebounce", bus_if.State, 2'd0);
        run(30, 4);
        check("s6_regrace", bus_if.State, 2'd1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) ign  = ~ign;
            if ($urandom_range(0, 39) == 0) door = ~door;
            if ($urandom_range(0, 39) == 0) belt = ~belt;
            snz = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 2) == 0);
        end
        snz = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
